controlador_cpu: RTL and testbench

CONTROLADOR_CPU -- requirements
Module: controlador_cpu

---
 rtl/controlador_cpu.sv | 221 ++++++++++++++++++++++
 tb/tb_controlador_cpu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_cpu.sv
// controlador_cpu: button-driven instruction sequencer for a 16x16 register file
// and an external combinational ALU (latch -> read -> execute -> write/display).
`default_nettype none

module controlador_cpu #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enviar,
   input  logic [2:0]  opcode,
   input  logic [3:0]  d1,
   input  logic [3:0]  r2,
   input  logic [3:0]  r3,
   input  logic [6:0]  entrada,
   output logic [3:0]  rf_raddr_a,
   output logic [3:0]  rf_raddr_b,
   input  logic [15:0] rf_rdata_a,
   input  logic [15:0] rf_rdata_b,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic [2:0]  alu_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [6:0]  alu_imm,
   input  logic [15:0] alu_result,
   output logic        busy,
   output logic        done,
   output logic [15:0] saida
);

   localparam int          CW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [2:0]  OP_CLEAR  = 3'b110;
   localparam logic [2:0]  OP_SHOW   = 3'b111;

   typedef enum logic [2:0] {
      S_CLEAR = 3'd0,
      S_IDLE  = 3'd1,
      S_READ  = 3'd2,
      S_EXEC  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic [CW-1:0]          db_cnt_q;
   logic [CW-1:0]          arm_cnt_q;
   logic                   db_q;
   logic                   armed_q;
   logic                   accept_q;
   logic                   sync_bit;
   logic                   sync_vld;

   assign sync_bit = sync_q[SYNC_STAGES-1];
   assign sync_vld = vld_q[SYNC_STAGES-1];

   // Accepts require the button to have been seen released after reset, so a
   // button held through reset release cannot fire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         vld_q     <= '0;
         db_cnt_q  <= '0;
         arm_cnt_q <= '0;
         db_q      <= 1'b0;
         armed_q   <= 1'b0;
         accept_q  <= 1'b0;
      end else begin
         sync_q   <= (sync_q << 1) | SYNC_STAGES'(enviar);
         vld_q    <= (vld_q << 1) | SYNC_STAGES'(1'b1);
         accept_q <= 1'b0;
         if (sync_vld) begin
            if (sync_bit != db_q) begin
               if (db_cnt_q == CW'(HOLD_CYCLES - 1)) begin
                  db_q     <= sync_bit;
                  db_cnt_q <= '0;
                  accept_q <= sync_bit & armed_q;
               end else begin
                  db_cnt_q <= db_cnt_q + CW'(1);
               end
            end else begin
               db_cnt_q <= '0;
            end
            if (!armed_q) begin
               if (sync_bit) begin
                  arm_cnt_q <= '0;
               end else if (arm_cnt_q == CW'(HOLD_CYCLES - 1)) begin
                  armed_q <= 1'b1;
               end else begin
                  arm_cnt_q <= arm_cnt_q + CW'(1);
               end
            end
         end
      end
   end

   state_t      state_q, state_d;
   logic        boot_q, boot_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic [15:0] saida_q, saida_d;
   logic        latch;
   logic [2:0]  opcode_q;
   logic [3:0]  d1_q, r2_q, r3_q;
   logic [6:0]  entrada_q;
   logic [15:0] rda_q, rdb_q, res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         boot_q    <= 1'b0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         saida_q   <= '0;
         opcode_q  <= '0;
         d1_q      <= '0;
         r2_q      <= '0;
         r3_q      <= '0;
         entrada_q <= '0;
         rda_q     <= '0;
         rdb_q     <= '0;
         res_q     <= '0;
      end else begin
         state_q <= state_d;
         boot_q  <= boot_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         saida_q <= saida_d;
         if (latch) begin
            opcode_q  <= opcode;
            d1_q      <= d1;
            r2_q      <= r2;
            r3_q      <= r3;
            entrada_q <= entrada;
         end
         if (state_q == S_READ) begin
            rda_q <= rf_rdata_a;
            rdb_q <= rf_rdata_b;
         end
         if (state_q == S_EXEC) begin
            res_q <= alu_result;
         end
      end
   end

   // Reset parks the FSM in IDLE with boot_q clear, so outputs are quiet during
   // reset and the first clock afterwards launches the clearing sweep.
   always_comb begin
      state_d    = state_q;
      boot_d     = boot_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      saida_d    = saida_q;
      latch      = 1'b0;
      busy       = 1'b1;
      rf_raddr_a = '0;
      rf_raddr_b = '0;
      rf_we      = 1'b0;
      rf_waddr   = '0;
      rf_wdata   = '0;
      alu_op     = '0;
      alu_a      = '0;
      alu_b      = '0;
      alu_imm    = '0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (!boot_q) begin
               boot_d  = 1'b1;
               state_d = S_CLEAR;
            end else if (accept_q) begin
               latch   = 1'b1;
               state_d = (opcode == OP_CLEAR) ? S_CLEAR : S_READ;
            end
         end
         S_CLEAR: begin
            rf_we    = 1'b1;
            rf_waddr = cnt_q;
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = S_IDLE;
               saida_d = '0;
               done_d  = 1'b1;
            end
         end
         S_READ: begin
            rf_raddr_a = r2_q;
            rf_raddr_b = r3_q;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            alu_op  = opcode_q;
            alu_a   = rda_q;
            alu_b   = rdb_q;
            alu_imm = entrada_q;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (opcode_q != OP_SHOW) begin
               rf_we    = 1'b1;
               rf_waddr = d1_q;
               rf_wdata = res_q;
               saida_d  = res_q;
            end else begin
               saida_d  = rda_q;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign done  = done_q;
   assign saida = saida_q;

endmodule

`default_nettype wire

// File: tb/tb_controlador_cpu.sv
// tb_controlador_cpu: randomized transaction-level check of controlador_cpu
// against a behavioural register-file/ALU model.
`default_nettype none

module tb_controlador_cpu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enviar;
   logic [2:0]  opcode;
   logic [3:0]  d1, r2, r3;
   logic [6:0]  entrada;
   logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
   logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
   logic        rf_we;
   logic [2:0]  alu_op;
   logic [15:0] alu_a, alu_b, alu_result;
   logic [6:0]  alu_imm;
   logic        busy, done;
   logic [15:0] saida;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;

   logic [15:0] rf     [16];
   logic [15:0] exp_rf [16];

   controlador_cpu #(.SYNC_STAGES(2), .HOLD_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .enviar(enviar),
      .opcode(opcode), .d1(d1), .r2(r2), .r3(r3), .entrada(entrada),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
      .alu_result(alu_result),
      .busy(busy), .done(done), .saida(saida)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [6:0] imm);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return (a << 7) | {9'd0, imm};
         default: return a;
      endcase
   endfunction

   assign rf_rdata_a = rf[rf_raddr_a];
   assign rf_rdata_b = rf[rf_raddr_b];
   assign alu_result = alu_f(alu_op, alu_a, alu_b, alu_imm);

   always @(posedge clk) begin
      if (rf_we) begin
         rf[rf_waddr] <= rf_wdata;
         wr_cnt       <= wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      opcode  = 3'($urandom);
      d1      = 4'($urandom);
      r2      = 4'($urandom);
      r3      = 4'($urandom);
      entrada = 7'($urandom);
   endtask

   task automatic quiet(input int n, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (busy) seen = 1'b1;
      end
      check(tag, {31'd0, seen}, 32'd0);
   endtask

   // Waits for the sweep to begin, then expects 16 zero writes to 0..15 and a done pulse.
   task automatic sweep_check(input bit press_during, input int max_wait, output int waited);
      int wr0;
      waited = 0;
      while (!busy && waited < max_wait) begin
         tick();
         waited++;
      end
      check("sweep_start", {31'd0, busy}, 32'd1);
      wr0 = wr_cnt;
      for (int i = 0; i < 16; i++) begin
         check("sweep_we",    {31'd0, rf_we}, 32'd1);
         check("sweep_addr",  {28'd0, rf_waddr}, i);
         check("sweep_data",  {16'd0, rf_wdata}, 32'd0);
         check("sweep_busy",  {31'd0, busy}, 32'd1);
         if (press_during) begin
            if (i == 1)  enviar = 1'b0;
            if (i == 6)  enviar = 1'b1;
            if (i == 14) enviar = 1'b0;
         end
         tick();
      end
      check("sweep_done",   {31'd0, done}, 32'd1);
      check("sweep_idle",   {31'd0, busy}, 32'd0);
      check("sweep_saida",  {16'd0, saida}, 32'd0);
      check("sweep_nwr",    wr_cnt - wr0, 32'd16);
      for (int i = 0; i < 16; i++) exp_rf[i] = 16'd0;
   endtask

   task automatic do_instr(input logic [2:0] op, input logic [3:0] d, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [6:0] imm, input int extra_hold);
      int          w = 0;
      int          wr0;
      logic [15:0] a, b, res;
      opcode = op; d1 = d; r2 = ra; r3 = rb; entrada = imm;
      enviar = 1'b1;
      while (!busy && w < 30) begin
         tick();
         w++;
      end
      check("accept", {31'd0, busy}, 32'd1);
      if (!busy) begin
         enviar = 1'b0;
         return;
      end
      check("rd_addr_a", {28'd0, rf_raddr_a}, {28'd0, ra});
      check("rd_addr_b", {28'd0, rf_raddr_b}, {28'd0, rb});
      check("rd_we",     {31'd0, rf_we}, 32'd0);
      check("rd_aluop",  {29'd0, alu_op}, 32'd0);
      a   = exp_rf[ra];
      b   = exp_rf[rb];
      res = alu_f(op, a, b, imm);
      wr0 = wr_cnt;
      scramble();
      tick();
      check("ex_op",  {29'd0, alu_op}, {29'd0, op});
      check("ex_a",   {16'd0, alu_a}, {16'd0, a});
      check("ex_b",   {16'd0, alu_b}, {16'd0, b});
      check("ex_imm", {25'd0, alu_imm}, {25'd0, imm});
      tick();
      if (op != 3'b111) begin
         check("wr_we",   {31'd0, rf_we}, 32'd1);
         check("wr_addr", {28'd0, rf_waddr}, {28'd0, d});
         check("wr_data", {16'd0, rf_wdata}, {16'd0, res});
      end else begin
         check("show_we", {31'd0, rf_we}, 32'd0);
      end
      tick();
      check("fin_done",  {31'd0, done}, 32'd1);
      check("fin_busy",  {31'd0, busy}, 32'd0);
      check("fin_saida", {16'd0, saida}, (op == 3'b111) ? {16'd0, a} : {16'd0, res});
      check("fin_nwr",   wr_cnt - wr0, (op == 3'b111) ? 32'd0 : 32'd1);
      if (op != 3'b111) exp_rf[d] = res;
      quiet(6 + extra_hold, "held_no_repeat");
      enviar = 1'b0;
      quiet(10, "release_quiet");
   endtask

   initial begin
      int waited;
      int wr0;
      logic [2:0] op;
      rst_n = 1'b0;
      enviar = 1'b0;
      opcode = '0; d1 = '0; r2 = '0; r3 = '0; entrada = '0;
      for (int i = 0; i < 16; i++) exp_rf[i] = 16'd0;
      tick(); tick(); tick();
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_we",    {31'd0, rf_we}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_saida", {16'd0, saida}, 32'd0);
      check("rst_waddr", {28'd0, rf_waddr}, 32'd0);
      check("rst_wdata", {16'd0, rf_wdata}, 32'd0);

      rst_n = 1'b1;
      sweep_check(1'b0, 5, waited);
      check("boot_latency", waited, 32'd1);
      quiet(12, "boot_quiet");

      do_instr(3'd5, 4'd1, 4'd0, 4'd0, 7'd3, 0);
      do_instr(3'd5, 4'd2, 4'd0, 4'd0, 7'd4, 0);
      do_instr(3'd0, 4'd5, 4'd1, 4'd2, 7'($urandom), 0);
      check("add_result", {16'd0, saida}, 32'h0007);

      do_instr(3'd5, 4'd3, 4'd0, 4'd0, 7'h02, 0);
      do_instr(3'd5, 4'd3, 4'd3, 4'd0, 7'h7D, 0);
      do_instr(3'd5, 4'd3, 4'd3, 4'd0, 7'h6F, 0);
      do_instr(3'd7, 4'($urandom), 4'd3, 4'($urandom), 7'($urandom), 0);
      check("show_beef", {16'd0, saida}, 32'h0000BEEF);

      for (int k = 0; k < 12; k++) begin
         op = 3'($urandom_range(0, 6));
         if (op == 3'd6) op = 3'd7;
         do_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), 7'($urandom), 0);
      end
      do_instr(3'd0, 4'd9, 4'd5, 4'd1, 7'd0, 100);

      enviar = 1'b1;
      tick(); tick();
      enviar = 1'b0;
      quiet(20, "short_press");

      opcode = 3'b110;
      enviar = 1'b1;
      sweep_check(1'b1, 30, waited);
      enviar = 1'b0;
      quiet(25, "busy_press_dropped");

      do_instr(3'd5, 4'd1, 4'd0, 4'd0, 7'd11, 0);
      opcode = 3'd0; d1 = 4'd9; r2 = 4'd1; r3 = 4'd1; entrada = '0;
      enviar = 1'b1;
      waited = 0;
      while (!busy && waited < 30) begin
         tick();
         waited++;
      end
      check("abort_accept", {31'd0, busy}, 32'd1);
      tick();
      wr0 = wr_cnt;
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_we",   {31'd0, rf_we}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_saida", {16'd0, saida}, 32'd0);
      tick(); tick(); tick();
      check("abort_nowr", wr_cnt - wr0, 32'd0);
      rst_n = 1'b1;
      sweep_check(1'b0, 5, waited);
      check("abort_latency", waited, 32'd1);
      quiet(30, "held_through_reset");
      enviar = 1'b0;
      quiet(12, "post_release");
      do_instr(3'd4, 4'd7, 4'd0, 4'd0, 7'($urandom), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
